// File: rtl/odd_stream_tx.sv
// Buffered byte source driving the odd-occurrence detector's integers/N/latch_in interface.
// Optional ODD_TX_CHECK_EN adds a running-XOR cross-check of the returned result.
module odd_stream_tx #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  input  logic       start,
  output logic       busy,
  output logic [7:0] integers,
  output logic [7:0] N,
  output logic       latch_in,
  input  logic       ready,
  input  logic [7:0] out_value,
  output logic [7:0] result,
  output logic       done,
  output logic       timeout_err,
  output logic       mismatch
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYC);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_WAIT_RDY,
    S_FINISH
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf [DEPTH];
  logic [7:0]    r_count;
  logic [7:0]    r_idx;
  logic [HW-1:0] r_hcnt;
  logic [TW-1:0] r_tcnt;
  logic          r_full;
  logic          r_busy;
  logic [7:0]    r_integers;
  logic [7:0]    r_n;
  logic          r_latch;
  logic [7:0]    r_result;
  logic          r_done;
  logic          r_timeout_err;

  logic          w_start_ok;
  logic          w_wr_ok;
  logic          w_hold_done;
  logic [7:0]    w_next_idx;
  logic          w_more;

  assign w_start_ok  = (r_state == S_IDLE) && start && (r_count != 8'd0);
  assign w_wr_ok     = (r_state == S_IDLE) && wr_en && !start && (r_count != DEPTH_B);
  assign w_hold_done = (r_hcnt == HOLD_LAST);
  assign w_next_idx  = r_idx + 8'd1;
  assign w_more      = (w_next_idx < r_count);

  // Storage is not reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_buf[r_count[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_idx         <= '0;
      r_hcnt        <= '0;
      r_tcnt        <= '0;
      r_full        <= 1'b0;
      r_busy        <= 1'b0;
      r_integers    <= '0;
      r_n           <= '0;
      r_latch       <= 1'b0;
      r_result      <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state       <= S_SETUP;
            r_n           <= r_count;
            r_integers    <= r_buf[0];
            r_idx         <= '0;
            r_hcnt        <= '0;
            r_latch       <= 1'b0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
          end else if (w_wr_ok) begin
            r_count <= r_count + 8'd1;
            r_full  <= ((r_count + 8'd1) == DEPTH_B);
          end
        end

        S_SETUP: begin
          if (w_hold_done) begin
            r_hcnt  <= '0;
            r_latch <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (w_hold_done) begin
            r_hcnt  <= '0;
            r_latch <= 1'b0;
            r_state <= S_LOW;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end

        S_LOW: begin
          if (w_hold_done) begin
            r_hcnt <= '0;
            if (w_more) begin
              r_idx      <= w_next_idx;
              r_integers <= r_buf[w_next_idx[AW-1:0]];
              r_state    <= S_SETUP;
            end else begin
              r_tcnt  <= '0;
              r_state <= S_WAIT_RDY;
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end

        // ready is checked first so it wins over a coincident timeout.
        S_WAIT_RDY: begin
          if (ready) begin
            r_result <= out_value;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end else if (r_tcnt == TO_LAST) begin
            r_result      <= '0;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        S_FINISH: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_n        <= '0;
          r_integers <= '0;
          r_count    <= '0;
          r_full     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ODD_TX_CHECK_EN
  logic [7:0] r_xor;
  logic       r_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xor      <= '0;
      r_mismatch <= 1'b0;
    end else if (w_start_ok) begin
      r_xor      <= '0;
      r_mismatch <= 1'b0;
    end else if (r_state == S_SETUP && w_hold_done) begin
      r_xor <= r_xor ^ r_integers;
    end else if (r_state == S_FINISH && !r_timeout_err && (r_result != r_xor)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

  assign wr_full     = r_full;
  assign busy        = r_busy;
  assign integers    = r_integers;
  assign N           = r_n;
  assign latch_in    = r_latch;
  assign result      = r_result;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule
